// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel registered mux with built-in fixed-priority or round-robin arbitration
// and a valid/ready handshake. Optional macro MUXN_FORCE_EN adds force_en/force_sel override.
module mux_arb_n #(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MODE  = 1,
   parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
`ifdef MUXN_FORCE_EN
   input  logic               force_en,
   input  logic [SEL_W-1:0]   force_sel,
`endif
   input  logic               out_ready
);

   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic [SEL_W-1:0]   r_out_sel;
   logic [SEL_W-1:0]   r_ptr;

   logic               w_load;
   logic               w_arb_found;
   logic [SEL_W-1:0]   w_arb_idx;
   logic               w_found;
   logic [SEL_W-1:0]   w_idx;
   logic [N-1:0]       w_grant;
   logic [WIDTH-1:0]   w_data;

   // The output register can take a new word when empty or being drained this cycle.
   assign w_load = !r_out_valid || out_ready;

   // Round-robin first looks above the pointer, then wraps to the lowest valid channel;
   // fixed priority only uses the second (lowest-index) pass.
   always_comb begin
      w_arb_found = 1'b0;
      w_arb_idx   = '0;
      if (MODE != 0) begin
         for (int i = 0; i < N; i++) begin
            if (!w_arb_found && in_valid[i] && (32'(i) > 32'(r_ptr))) begin
               w_arb_found = 1'b1;
               w_arb_idx   = SEL_W'(i);
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!w_arb_found && in_valid[i]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = SEL_W'(i);
         end
      end
   end

`ifdef MUXN_FORCE_EN
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      if (force_en) begin
         for (int i = 0; i < N; i++) begin
            if ((32'(force_sel) == 32'(i)) && in_valid[i]) begin
               w_found = 1'b1;
               w_idx   = SEL_W'(i);
            end
         end
      end else begin
         w_found = w_arb_found;
         w_idx   = w_arb_idx;
      end
   end
`else
   assign w_found = w_arb_found;
   assign w_idx   = w_arb_idx;
`endif

   always_comb begin
      w_grant = '0;
      w_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (w_found && (w_idx == SEL_W'(i))) begin
            w_grant[i] = 1'b1;
            w_data     = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready = w_grant & {N{w_load}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_ptr       <= SEL_W'(N - 1);
      end else if (w_load) begin
         r_out_valid <= w_found;
         if (w_found) begin
            r_out_data <= w_data;
            r_out_sel  <= w_idx;
            r_ptr      <= w_idx;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_arb_n.sv
// Testbench for mux_arb_n: a fixed-priority and a round-robin instance share stimulus;
// a behavioural model predicts grants and a monitor checks outputs from per-instance queues.
`timescale 1ns/1ps
module tb_mux_arb_n;
   localparam int N     = 4;
   localparam int WIDTH = 8;
   localparam int SEL_W = 2;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [N-1:0]       in_valid = '0;
   logic [N*WIDTH-1:0] in_data = '0;
   logic               out_ready = 1'b0;
`ifdef MUXN_FORCE_EN
   logic               force_en = 1'b0;
   logic [SEL_W-1:0]   force_sel = '0;
`endif

   logic [N-1:0]       in_ready [2];
   logic               out_valid [2];
   logic [WIDTH-1:0]   out_data [2];
   logic [SEL_W-1:0]   out_sel [2];

   int   checks = 0;
   int   failures = 0;
   exp_t q [2][$];
   bit   m_valid [2];
   int   m_ptr [2];

   always #5 clk = ~clk;

   // Index 0: fixed priority, index 1: round-robin
   mux_arb_n #(.N(N), .WIDTH(WIDTH), .MODE(0)) u_fp (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
      .out_sel(out_sel[0]),
`ifdef MUXN_FORCE_EN
      .force_en(force_en), .force_sel(force_sel),
`endif
      .out_ready(out_ready));

   mux_arb_n #(.N(N), .WIDTH(WIDTH), .MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
      .out_sel(out_sel[1]),
`ifdef MUXN_FORCE_EN
      .force_en(force_en), .force_sel(force_sel),
`endif
      .out_ready(out_ready));

   task automatic check(string name, int m, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s mode=%0d actual=%0h required=%0h t=%0t", name, m, act, exp, $time);
      end
   endtask

   // Channel chosen by the arbitration rules, or -1 when nothing may be granted.
   function automatic int model_grant(int mode, int ptr, logic [N-1:0] v);
      int c;
`ifdef MUXN_FORCE_EN
      if (force_en)
         return (int'(force_sel) < N && v[force_sel]) ? int'(force_sel) : -1;
`endif
      for (int k = 1; k <= N; k++) begin
         c = (mode == 1) ? (ptr + k) % N : k - 1;
         if (v[2'(c)]) return c;
      end
      return -1;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
               check("out_valid", m, 32'(out_valid[m]), 32'(q[m].size() > 0));
               if (out_valid[m] && q[m].size() > 0) begin
                  e = q[m][0];
                  check("out_data", m, 32'(out_data[m]), 32'(e.data));
                  check("out_sel", m, 32'(out_sel[m]), 32'(e.sel));
                  if (out_ready) void'(q[m].pop_front());
               end
            end
         end
      end
   end

   task automatic step(logic [N-1:0] v, logic [N*WIDTH-1:0] d, logic rdy);
      bit           load;
      int           g;
      logic [N-1:0] exp_rdy;
      exp_t         e;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      @(negedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         load    = !m_valid[m] || rdy;
         g       = model_grant(m, m_ptr[m], v);
         exp_rdy = '0;
         if (load && g >= 0) exp_rdy[2'(g)] = 1'b1;
         check("in_ready", m, 32'(in_ready[m]), 32'(exp_rdy));
         check("in_ready_onehot", m, 32'($countones(in_ready[m]) <= 1), 32'd1);
         if (load) begin
            m_valid[m] = (g >= 0);
            if (g >= 0) begin
               e.data = d[g*WIDTH +: WIDTH];
               e.sel  = SEL_W'(g);
               q[m].push_back(e);
               m_ptr[m] = g;
            end
         end
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         q[m].delete();
         m_valid[m] = 1'b0;
         m_ptr[m]   = N - 1;
      end
   endtask

   task automatic check_reset_outputs();
      for (int m = 0; m < 2; m++) begin
         check("rst_out_valid", m, 32'(out_valid[m]), 32'd0);
         check("rst_out_data", m, 32'(out_data[m]), 32'd0);
         check("rst_out_sel", m, 32'(out_sel[m]), 32'd0);
      end
   endtask

   // Reset asserted while the clock is high, away from both edges.
   task automatic async_reset();
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = '0;
      #1;
      check_reset_outputs();
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin : stim
      logic [N*WIDTH-1:0] d;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;

      // All channels valid: round-robin rotates, fixed priority stays on 0
      for (int c = 0; c < 8; c++) step(4'b1111, 32'hA3A2A1A0, 1'b1);
      step(4'b0000, 32'h0, 1'b1);

      // Channels 1 and 3 valid: fixed priority never serves channel 3
      for (int c = 0; c < 6; c++) step(4'b1010, 32'($urandom), 1'b1);
      step(4'b0000, 32'h0, 1'b1);

      // Load 0x5C from channel 2, stall three cycles, then pop and refill from channel 0
      step(4'b0100, 32'h005C0000, 1'b1);
      for (int c = 0; c < 3; c++) step(4'b0001, 32'h00000011, 1'b0);
      step(4'b0001, 32'h00000011, 1'b1);
      step(4'b0000, 32'h0, 1'b1);

      // Every valid pattern, each followed by an idle cycle
      for (int p = 0; p < 16; p++) begin
         step(4'(p), 32'($urandom), 1'($urandom));
         step(4'b0000, 32'($urandom), 1'b1);
      end

      // Reset in the middle of traffic with a word held
      step(4'b1111, 32'($urandom), 1'b0);
      step(4'b1111, 32'($urandom), 1'b0);
      async_reset();

      for (int c = 0; c < 400; c++) begin
         d = 32'($urandom);
         step(4'($urandom), d, 1'($urandom_range(0, 3) != 0));
      end
      step(4'b0000, 32'h0, 1'b1);

`ifdef MUXN_FORCE_EN
      force_en  = 1'b1;
      force_sel = 2'd2;
      step(4'b1011, 32'h44332211, 1'b1);
      step(4'b0100, 32'h44332211, 1'b1);
      step(4'b0000, 32'h0, 1'b1);
      for (int c = 0; c < 60; c++) begin
         force_en  = 1'($urandom);
         force_sel = 2'($urandom);
         step(4'($urandom), 32'($urandom), 1'($urandom));
      end
      force_en = 1'b0;
`endif

      step(4'b0000, 32'h0, 1'b1);
      step(4'b0000, 32'h0, 1'b1);
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
